// File: rtl/stream_byte_deserializer_pkg.sv
// Shared primitives for the byte-stream framework, extended with the
// deserializer state encoding and a byte-keep mask helper.
package stream_byte_deserializer_pkg;

    localparam int BYTE_W = 8;

    typedef logic [7:0]  ulogic8_t;
    typedef logic [31:0] ulogic32_t;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        FLUSH   = 2'd2
    } deser_state_t;

    // Contiguous low-order mask of nbytes ones (nbytes <= 8).
    function automatic logic [7:0] keep_mask(input int unsigned nbytes);
        return 8'((16'd1 << nbytes) - 16'd1);
    endfunction

endpackage

// File: rtl/stream_byte_deserializer_if.sv
// Byte-in / word-out valid-ready channel pair of the deserializer.
interface stream_byte_deserializer_if
    import stream_byte_deserializer_pkg::*;
#(
    parameter int NUM_BYTES = 4
);
    localparam int DATA_W = BYTE_W * NUM_BYTES;

    logic                 s_valid;
    logic                 s_ready;
    ulogic8_t             s_data;
    logic                 s_last;
    logic                 m_valid;
    logic                 m_ready;
    logic [DATA_W-1:0]    m_data;
    logic [NUM_BYTES-1:0] m_keep;
    logic                 m_last;

    // Deserializer side.
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_keep, m_last
    );

    // Environment side: byte source and word sink.
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_keep, m_last
    );

endinterface

// File: rtl/stream_byte_deserializer.sv
// Collects LSB-first bytes into NUM_BYTES-wide words; s_last closes a word
// early with a contiguous keep mask. One registered output word.
module stream_byte_deserializer
    import stream_byte_deserializer_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    stream_byte_deserializer_if.slave  bus,
    output logic                       ovf_err
);

    localparam int DATA_W = BYTE_W * NUM_BYTES;
    localparam int CNT_W  = $clog2(NUM_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    deser_state_t         r_state, w_state_nxt;
    logic                 r_en;
    logic [CNT_W-1:0]     r_cnt;
    logic [DATA_W-1:0]    r_asm;
    logic [DATA_W-1:0]    r_mdata;
    logic [NUM_BYTES-1:0] r_mkeep;
    logic                 r_mlast;
    logic                 r_mvalid;
    logic [NUM_BYTES-1:0] r_pkeep;
    logic                 r_plast;
    logic                 r_ovf;

    logic                 w_out_free;
    logic                 w_s_ready;
    logic                 w_acc;
    logic                 w_done;
    logic                 w_hold_rel;
    logic [DATA_W-1:0]    w_merged;
    logic [NUM_BYTES-1:0] w_keep;

    // r_en keeps s_ready low until the first edge after reset release.
    assign w_out_free = !r_mvalid || bus.m_ready;
    assign w_s_ready  = (r_state == COLLECT) && r_en && w_out_free;
    assign w_acc      = bus.s_valid && w_s_ready && !flush;
    assign w_done     = w_acc && ((r_cnt == LAST_IDX) || bus.s_last);
    assign w_hold_rel = (r_state == HOLD) && w_out_free;
    assign w_merged   = r_asm | (DATA_W'(bus.s_data) << (BYTE_W * r_cnt));
    assign w_keep     = NUM_BYTES'(keep_mask(int'(r_cnt) + 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= COLLECT;
        else        r_state <= w_state_nxt;
    end

    // Next state. HOLD only guards against a word completing with the output
    // register still occupied; the s_ready gating keeps it unreachable.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            COLLECT: begin
                if (flush)                      w_state_nxt = FLUSH;
                else if (w_done && !w_out_free) w_state_nxt = HOLD;
            end
            HOLD:    if (w_out_free) w_state_nxt = COLLECT;
            FLUSH:   if (!flush)     w_state_nxt = COLLECT;
            default:                 w_state_nxt = COLLECT;
        endcase
    end

    // Counter, assembly register, output register and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en     <= FALSE;
            r_cnt    <= '0;
            r_asm    <= '0;
            r_mdata  <= '0;
            r_mkeep  <= '0;
            r_mlast  <= FALSE;
            r_mvalid <= FALSE;
            r_pkeep  <= '0;
            r_plast  <= FALSE;
            r_ovf    <= FALSE;
        end else begin
            r_en <= TRUE;
            if (flush && bus.s_valid && w_s_ready) r_ovf <= TRUE;

            // A parked HOLD word survives flush; anything else partial is dropped.
            if (flush && r_state != HOLD) begin
                r_cnt <= '0;
                r_asm <= '0;
            end else if (w_done) begin
                r_cnt <= '0;
                if (w_out_free) begin
                    r_asm <= '0;
                end else begin
                    r_asm   <= w_merged;
                    r_pkeep <= w_keep;
                    r_plast <= bus.s_last;
                end
            end else if (w_acc) begin
                r_asm <= w_merged;
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_hold_rel) begin
                r_asm <= '0;
            end

            if (w_done && w_out_free) begin
                r_mdata  <= w_merged;
                r_mkeep  <= w_keep;
                r_mlast  <= bus.s_last;
                r_mvalid <= TRUE;
            end else if (w_hold_rel) begin
                r_mdata  <= r_asm;
                r_mkeep  <= r_pkeep;
                r_mlast  <= r_plast;
                r_mvalid <= TRUE;
            end else if (r_mvalid && bus.m_ready) begin
                r_mvalid <= FALSE;
            end
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = r_mvalid;
    assign bus.m_data  = r_mdata;
    assign bus.m_keep  = r_mkeep;
    assign bus.m_last  = r_mlast;
    assign ovf_err     = r_ovf;

`ifndef SYNTHESIS
    a_no_hold: assert property (@(posedge clk) disable iff (!rst_n)
        r_state != HOLD);

    a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
        bus.m_valid && !bus.m_ready |=> bus.m_valid && $stable(bus.m_data)
            && $stable(bus.m_keep) && $stable(bus.m_last));

    a_in_stable: assert property (@(posedge clk) disable iff (!rst_n)
        bus.s_valid && !bus.s_ready |=> bus.s_valid && $stable(bus.s_data)
            && $stable(bus.s_last));

    a_keep_contig: assert property (@(posedge clk) disable iff (!rst_n)
        bus.m_valid |-> (bus.m_keep != '0) && ((bus.m_keep & (bus.m_keep + 1'b1)) == '0));
`endif

endmodule

// File: tb/tb_stream_byte_deserializer.sv
// Bench for stream_byte_deserializer (NUM_BYTES=4): vector table, directed
// stall/flush/reset sequences, then random traffic against a packet model.
module tb_stream_byte_deserializer;
    import stream_byte_deserializer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
    logic ovf_err;

    stream_byte_deserializer_if #(.NUM_BYTES(4)) bus();

    stream_byte_deserializer #(.NUM_BYTES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .bus     (bus),
        .ovf_err (ovf_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    typedef struct packed {
        logic [7:0]  d;
        logic        l;
        logic        ev;
        logic [31:0] ed;
        logic [3:0]  ek;
        logic        el;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } wrd_t;

    vec_t vt[10];
    wrd_t exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send n bytes of w LSB-first, one per cycle, then check the word produced.
    task automatic send_chk(input string nm, input logic [31:0] w, input int n,
                            input logic lst, input logic [31:0] ed, input logic [3:0] ek);
        bus.m_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = w[8*k +: 8];
            bus.s_last  = lst && (k == n - 1);
            tick();
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        chk({nm, "_valid"}, 64'(bus.m_valid), 64'(1'b1));
        chk({nm, "_data"},  64'(bus.m_data),  64'(ed));
        chk({nm, "_keep"},  64'(bus.m_keep),  64'(ek));
        chk({nm, "_last"},  64'(bus.m_last),  64'(lst));
    endtask

    initial begin
        int n_acc, cyc, bubbles, noncontig, mdl_n, guard;
        logic [31:0] mdl_w;
        logic acc, outh;
        wrd_t got, exp;

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;

        // Reset state
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", 64'(bus.m_valid), 64'(1'b0));
        chk("rst_m_data",  64'(bus.m_data),  64'(0));
        chk("rst_m_keep",  64'(bus.m_keep),  64'(0));
        chk("rst_m_last",  64'(bus.m_last),  64'(1'b0));
        chk("rst_ovf",     64'(ovf_err),     64'(1'b0));
        chk("rst_s_ready", 64'(bus.s_ready), 64'(1'b0));
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("rel_s_ready", 64'(bus.s_ready), 64'(1'b1));

        // Vector table: two packets, output checked one cycle after each byte
        vt[0] = '{8'h11, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vt[1] = '{8'h22, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vt[2] = '{8'h33, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vt[3] = '{8'h44, 1'b0, 1'b1, 32'h44332211, 4'hF, 1'b0};
        vt[4] = '{8'hA0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vt[5] = '{8'hA1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vt[6] = '{8'hA2, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vt[7] = '{8'hA3, 1'b0, 1'b1, 32'hA3A2A1A0, 4'hF, 1'b0};
        vt[8] = '{8'hA4, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        vt[9] = '{8'hA5, 1'b1, 1'b1, 32'h0000A5A4, 4'h3, 1'b1};
        bus.m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = vt[i].d;
            bus.s_last  = vt[i].l;
            chk("vec_s_ready", 64'(bus.s_ready), 64'(1'b1));
            tick();
            chk("vec_m_valid", 64'(bus.m_valid), 64'(vt[i].ev));
            if (vt[i].ev) begin
                chk("vec_m_data", 64'(bus.m_data), 64'(vt[i].ed));
                chk("vec_m_keep", 64'(bus.m_keep), 64'(vt[i].ek));
                chk("vec_m_last", 64'(bus.m_last), 64'(vt[i].el));
            end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        tick();
        chk("vec_drained", 64'(bus.m_valid), 64'(1'b0));

        // Downstream stall for 5 cycles with a byte waiting
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus.m_ready = 1'b0;
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(8'hC1 + k);
            tick();
        end
        bus.s_data = 8'h55;
        for (int k = 0; k < 5; k++) begin
            chk("stall_s_ready", 64'(bus.s_ready), 64'(1'b0));
            chk("stall_m_valid", 64'(bus.m_valid), 64'(1'b1));
            chk("stall_m_data",  64'(bus.m_data),  64'(32'hC4C3C2C1));
            tick();
        end
        bus.m_ready = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        chk("unstall_m_valid", 64'(bus.m_valid), 64'(1'b0));
        chk("unstall_s_ready", 64'(bus.s_ready), 64'(1'b1));
        send_chk("stall_next", 32'h00887766, 3, 1'b0, 32'h88776655, 4'hF);

        // Flush after two bytes
        tick();
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h01;
        tick();
        bus.s_data  = 8'h02;
        tick();
        bus.s_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("flush_s_ready", 64'(bus.s_ready), 64'(1'b0));
        tick();
        chk("flush_back", 64'(bus.s_ready), 64'(1'b1));
        send_chk("flush_word", 32'hDDCCBBAA, 4, 1'b0, 32'hDDCCBBAA, 4'hF);
        chk("ovf_clear", 64'(ovf_err), 64'(1'b0));

        // Flush coinciding with an accepted byte
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hEE;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.s_valid = 1'b0;
        chk("ovf_set", 64'(ovf_err), 64'(1'b1));
        tick();
        tick();
        chk("ovf_sticky", 64'(ovf_err), 64'(1'b1));
        send_chk("post_ovf", 32'h04030201, 4, 1'b0, 32'h04030201, 4'hF);
        chk("ovf_sticky2", 64'(ovf_err), 64'(1'b1));

        // Asynchronous reset mid-word
        tick();
        send_chk("pre_rst", 32'h5A6B7C8D, 4, 1'b1, 32'h5A6B7C8D, 4'hF);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h99;
        tick();
        bus.s_data  = 8'h98;
        tick();
        bus.s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_m_valid", 64'(bus.m_valid), 64'(1'b0));
        chk("arst_m_data",  64'(bus.m_data),  64'(0));
        chk("arst_m_keep",  64'(bus.m_keep),  64'(0));
        chk("arst_m_last",  64'(bus.m_last),  64'(1'b0));
        chk("arst_ovf",     64'(ovf_err),     64'(1'b0));
        chk("arst_s_ready", 64'(bus.s_ready), 64'(1'b0));
        @(negedge clk) rst_n = 1'b1;
        tick();
        send_chk("post_rst", 32'h0D0C0B0A, 4, 1'b0, 32'h0D0C0B0A, 4'hF);
        tick();

        // Random traffic against a packet-level model
        n_acc = 0; cyc = 0; bubbles = 0; noncontig = 0; mdl_n = 0; mdl_w = '0;
        while (n_acc < 1000 && cyc < 20000) begin
            if (!bus.s_valid && ($urandom % 4 != 0)) begin
                bus.s_valid = 1'b1;
                bus.s_data  = 8'($urandom);
                bus.s_last  = (n_acc == 999) || ($urandom % 8 == 0);
            end
            bus.m_ready = ($urandom % 4 != 0);
            #1;
            acc  = bus.s_valid && bus.s_ready;
            outh = bus.m_valid && bus.m_ready;
            if (bus.m_ready && !bus.s_ready) bubbles++;
            if (outh) begin
                got = '{bus.m_data, bus.m_keep, bus.m_last};
                if ((got.k == 4'h0) || ((got.k & (got.k + 4'h1)) != 4'h0)) noncontig++;
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_word", 64'(got), 64'(0));
                end else begin
                    exp = exp_q.pop_front();
                    chk("rnd_word", 64'(got), 64'(exp));
                end
            end
            if (acc) begin
                mdl_w[8*mdl_n +: 8] = bus.s_data;
                mdl_n++;
                n_acc++;
                if (mdl_n == 4 || bus.s_last) begin
                    exp_q.push_back('{mdl_w, 4'((1 << mdl_n) - 1), bus.s_last});
                    mdl_w = '0;
                    mdl_n = 0;
                end
            end
            tick();
            if (acc) begin
                bus.s_valid = 1'b0;
                bus.s_last  = 1'b0;
            end
            cyc++;
        end
        chk("rnd_bytes_sent", 64'(n_acc), 64'(1000));
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            #1;
            if (bus.m_valid) begin
                got = '{bus.m_data, bus.m_keep, bus.m_last};
                exp = exp_q.pop_front();
                chk("rnd_drain_word", 64'(got), 64'(exp));
            end
            tick();
            guard++;
        end
        chk("rnd_queue_empty", 64'(exp_q.size()), 64'(0));
        chk("rnd_no_bubble",   64'(bubbles),      64'(0));
        chk("rnd_keep_contig", 64'(noncontig),    64'(0));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
